// File: rtl/alu_bus_pkg.sv
// Shared types and constants for the multiplier bus host.
// DR_READBACK_EN adds the DR readback state and widens the response to 24 bits.
`timescale 1ns/1ps
package alu_bus_pkg;

  localparam int DATA_W = 8;
  localparam int INS_W  = 3;
  localparam int WAIT_W = 4;
  localparam int TO_W   = 8;

  // Datapath opcode encodings
  localparam logic [INS_W-1:0] INS_NOP = 3'b000;
  localparam logic [INS_W-1:0] INS_ADD = 3'b001;
  localparam logic [INS_W-1:0] INS_SUB = 3'b010;
  localparam logic [INS_W-1:0] INS_SHL = 3'b011;
  localparam logic [INS_W-1:0] INS_SHR = 3'b100;
  localparam logic [INS_W-1:0] INS_MUL = 3'b101;

  // Host sequencer state enumeration
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_LD_DR  = 4'd1;
  localparam state_t ST_LD_MQ  = 4'd2;
  localparam state_t ST_LD_ACC = 4'd3;
  localparam state_t ST_EXEC   = 4'd4;
  localparam state_t ST_WAIT   = 4'd5;
  localparam state_t ST_RD_ACC = 4'd6;
  localparam state_t ST_RD_MQ  = 4'd7;
  localparam state_t ST_RESP   = 4'd8;
`ifdef DR_READBACK_EN
  localparam state_t ST_RD_DR  = 4'd9;
`endif

  function automatic int rsp_width();
`ifdef DR_READBACK_EN
    return 3 * DATA_W;
`else
    return 2 * DATA_W;
`endif
  endfunction

  localparam int RSP_W = rsp_width();

endpackage

// File: rtl/alu_bus_wait_timer.sv
// Post-issue delay and RDY timeout counters for the bus host.
`timescale 1ns/1ps
module alu_bus_wait_timer
  import alu_bus_pkg::*;
#(
  parameter int MIN_WAIT       = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic sample,
  output logic expire
);

  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   to_cnt;

  always_ff @(posedge clock) begin
    // NOTE: plain counters take reset too; only large storage arrays go unreset.
    if (!reset_n) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else if (load) begin
      wait_cnt <= WAIT_W'(MIN_WAIT - 1);
      to_cnt   <= TO_W'(TIMEOUT_CYCLES);
    end else if (enable) begin
      // The timeout budget only drains once the minimum wait has elapsed.
      if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      else if (to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
    end
  end

  assign sample = (wait_cnt == '0);
  assign expire = (to_cnt == TO_W'(1));

endmodule

// File: rtl/alu_bus_host.sv
// Bus sequencer: loads DR/MQ/Acc, issues INS, waits for RDY, reads results back.
// Define DR_READBACK_EN to also read DR back into rsp_data[7:0].
`timescale 1ns/1ps
module alu_bus_host
  import alu_bus_pkg::*;
#(
  parameter int MIN_WAIT       = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [INS_W-1:0]   cmd_ins,
  input  logic [DATA_W-1:0]  cmd_a,
  input  logic [DATA_W-1:0]  cmd_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RSP_W-1:0]   rsp_data,
  output logic               rsp_timeout,
  output logic [INS_W-1:0]   INS,
  output logic [DATA_W-1:0]  inBUS,
  output logic               LDAcc,
  output logic               LDMQ,
  output logic               LDDR,
  output logic               STAcc,
  output logic               STMQ,
  output logic               STDR,
  output logic               TESTMODE,
  input  logic [DATA_W-1:0]  outBUS,
  input  logic               RDY
);

  state_t              state;
  state_t              next_state;
  logic [INS_W-1:0]    ins_q;
  logic [DATA_W-1:0]   a_q;
  logic                sample;
  logic                expire;
  logic                accept;
  logic                timeout_hit;

  alu_bus_wait_timer #(
    .MIN_WAIT       (MIN_WAIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (state == ST_EXEC),
    .enable  (state == ST_WAIT),
    .sample  (sample),
    .expire  (expire)
  );

  assign accept      = (state == ST_IDLE) && cmd_valid;
  assign timeout_hit = (state == ST_WAIT) && sample && !RDY && expire;
  assign TESTMODE    = 1'b0;

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE:   if (cmd_valid) next_state = ST_LD_DR;
      ST_LD_DR:  next_state = ST_LD_MQ;
      ST_LD_MQ:  next_state = ST_LD_ACC;
      ST_LD_ACC: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WAIT;
      ST_WAIT: begin
        if (sample) begin
          if (RDY)
            next_state = ST_RD_ACC;
          else if (expire)
            next_state = ST_RESP;
        end
      end
      ST_RD_ACC: next_state = ST_RD_MQ;
`ifdef DR_READBACK_EN
      ST_RD_MQ:  next_state = ST_RD_DR;
      ST_RD_DR:  next_state = ST_RESP;
`else
      ST_RD_MQ:  next_state = ST_RESP;
`endif
      ST_RESP:   if (rsp_ready) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state so each strobe lines up with its state.
  always_ff @(posedge clock) begin
    // NOTE: <= everywhere here so all registers update from pre-edge values.
    if (!reset_n) begin
      state       <= ST_IDLE;
      ins_q       <= '0;
      a_q         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      INS         <= '0;
      inBUS       <= '0;
      LDAcc       <= 1'b0;
      LDMQ        <= 1'b0;
      LDDR        <= 1'b0;
      STAcc       <= 1'b0;
      STMQ        <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == ST_IDLE);
      rsp_valid <= (next_state == ST_RESP);
      LDDR      <= (next_state == ST_LD_DR);
      LDMQ      <= (next_state == ST_LD_MQ);
      LDAcc     <= (next_state == ST_LD_ACC);
      STAcc     <= (next_state == ST_RD_ACC);
      STMQ      <= (next_state == ST_RD_MQ);
      INS       <= (next_state == ST_EXEC || next_state == ST_WAIT) ? ins_q : '0;

      // LD_DR is only ever entered from IDLE, so b comes straight off the command.
      if (next_state == ST_LD_DR)
        inBUS <= cmd_b;
      else if (next_state == ST_LD_MQ)
        inBUS <= a_q;
      else
        inBUS <= '0;

      if (accept) begin
        ins_q       <= cmd_ins;
        a_q         <= cmd_a;
        rsp_data    <= '0;
        rsp_timeout <= 1'b0;
      end

      if (state == ST_RD_ACC)
        rsp_data[RSP_W-1 -: DATA_W] <= outBUS;
      if (state == ST_RD_MQ)
        rsp_data[RSP_W-DATA_W-1 -: DATA_W] <= outBUS;
`ifdef DR_READBACK_EN
      if (state == ST_RD_DR)
        rsp_data[DATA_W-1:0] <= outBUS;
`endif

      if (timeout_hit) begin
        rsp_timeout <= 1'b1;
        rsp_data    <= '0;
      end
    end
  end

`ifdef DR_READBACK_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      STDR <= 1'b0;
    else
      STDR <= (next_state == ST_RD_DR);
  end
`else
  assign STDR = 1'b0;
`endif

endmodule

// File: tb/tb_alu_bus_host.sv
// Directed bench for alu_bus_host with a small multiplier datapath model and a response scoreboard.
`timescale 1ns/1ps
module tb_alu_bus_host;
  import alu_bus_pkg::*;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [INS_W-1:0]   cmd_ins;
  logic [DATA_W-1:0]  cmd_a;
  logic [DATA_W-1:0]  cmd_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [RSP_W-1:0]   rsp_data;
  logic               rsp_timeout;
  logic [INS_W-1:0]   INS;
  logic [DATA_W-1:0]  inBUS;
  logic               LDAcc, LDMQ, LDDR;
  logic               STAcc, STMQ, STDR;
  logic               TESTMODE;
  logic [DATA_W-1:0]  outBUS;
  logic               rdy_in;

  typedef struct {
    logic [RSP_W-1:0] data;
    logic             timeout;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   st_count = 0;
  int   viol = 0;

  always #5 clock = ~clock;

  alu_bus_host #(
    .MIN_WAIT       (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ins     (cmd_ins),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .INS         (INS),
    .inBUS       (inBUS),
    .LDAcc       (LDAcc),
    .LDMQ        (LDMQ),
    .LDDR        (LDDR),
    .STAcc       (STAcc),
    .STMQ        (STMQ),
    .STDR        (STDR),
    .TESTMODE    (TESTMODE),
    .outBUS      (outBUS),
    .RDY         (rdy_in)
  );

  // Datapath model: registers loaded from inBUS, product formed once per issue.
  logic [DATA_W-1:0] acc_m, mq_m, dr_m;
  logic              computed;

  always @(posedge clock) begin
    if (LDDR) dr_m <= inBUS;
    if (LDMQ) mq_m <= inBUS;
    if (LDAcc) begin
      acc_m    <= inBUS;
      computed <= 1'b0;
    end
    if (INS == INS_MUL && !computed) begin
      {acc_m, mq_m} <= 16'(mq_m) * 16'(dr_m);
      computed      <= 1'b1;
    end
  end

  assign outBUS = STAcc ? acc_m : STMQ ? mq_m : STDR ? dr_m : 8'h00;

  // Bus protocol monitor
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (STAcc || STMQ || STDR) st_count <= st_count + 1;
      if ((32'(STAcc) + 32'(STMQ) + 32'(STDR)) > 1 ||
          (32'(LDAcc) + 32'(LDMQ) + 32'(LDDR)) > 1 ||
          ((LDAcc || LDMQ || LDDR) && (STAcc || STMQ || STDR)) ||
          (!(LDDR || LDMQ) && inBUS != 8'h00) ||
          TESTMODE !== 1'b0)
        viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [RSP_W-1:0] exp_of(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
`ifdef DR_READBACK_EN
    return {p, b};
`else
    return p;
`endif
  endfunction

  // Drives one request and checks the load sequence; returns in the EXEC cycle.
  task automatic issue(input logic [2:0] ins, input logic [7:0] a, input logic [7:0] b);
    check("accept_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ins   = ins;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    check("ld_dr_strobe", LDDR, 1);
    check("ld_dr_bus", inBUS, b);
    check("busy_not_ready", cmd_ready, 0);
    tick();
    check("ld_mq_strobe", LDMQ, 1);
    check("ld_mq_bus", inBUS, a);
    tick();
    check("ld_acc_strobe", LDAcc, 1);
    check("ld_acc_bus", inBUS, 0);
    tick();
    check("exec_ins", INS, ins);
    check("exec_bus", inBUS, 0);
  endtask

  // Waits for a response, scores it, optionally applies backpressure, then releases it.
  task automatic collect(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    e.data    = '0;
    e.timeout = 1'b0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    rdy_in = 1'b0;
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    check({tag, "_rsp_data"}, rsp_data, e.data);
    check({tag, "_rsp_timeout"}, rsp_timeout, e.timeout);
    check({tag, "_resp_ins"}, INS, 0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_a     = 8'h55;
      cmd_b     = 8'hAA;
      tick();
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_data"}, rsp_data, e.data);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check({tag, "_idle_ready"}, cmd_ready, 1);
    check({tag, "_idle_valid"}, rsp_valid, 0);
    check({tag, "_no_early_accept"}, LDDR, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_ins   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    rdy_in    = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_strobes", {LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR}, 0);
    check("rst_ins", INS, 0);
    reset_n = 1'b1;
    tick();
    check("rel_cmd_ready", cmd_ready, 1);

    // Basic multiply, RDY on the last allowed sample
    issue(INS_MUL, 8'h0F, 8'h03);
    sb.push_back('{data: exp_of(8'h0F, 8'h03), timeout: 1'b0});
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("t1_wait_ins", INS, INS_MUL);
      check("t1_wait_no_st", STAcc, 0);
    end
    tick();
    rdy_in = 1'b1;
    check("t1_post5_no_st", STAcc, 0);
    tick();
    check("t1_rd_acc", STAcc, 1);
    check("t1_rd_acc_ins", INS, 0);
    tick();
    check("t1_rd_mq", STMQ, 1);
    check("t1_rd_mq_acc_low", STAcc, 0);
`ifdef DR_READBACK_EN
    tick();
    check("t1_rd_dr", STDR, 1);
    check("t1_rd_dr_mq_low", STMQ, 0);
`endif
    collect("t1", 0);

    // RDY already high at issue: sampling held off by MIN_WAIT, plus backpressure
    rdy_in = 1'b1;
    issue(INS_MUL, 8'hF3, 8'hB7);
    sb.push_back('{data: exp_of(8'hF3, 8'hB7), timeout: 1'b0});
    tick();
    check("t2_post1_no_st", STAcc, 0);
    check("t2_post1_ins", INS, INS_MUL);
    tick();
    check("t2_post2_no_st", STAcc, 0);
    tick();
    check("t2_post3_rd_acc", STAcc, 1);
    collect("t2", 10);

    // RDY stuck low: timeout after exactly four samples, no readback strobes
    st0 = st_count;
    issue(INS_MUL, 8'h07, 8'h09);
    sb.push_back('{data: '0, timeout: 1'b1});
    for (int n = 1; n <= 5; n++) begin
      tick();
      check("t3_wait_no_valid", rsp_valid, 0);
    end
    tick();
    check("t3_resp_now", rsp_valid, 1);
    collect("t3", 0);
    check("t3_no_st_strobes", st_count - st0, 0);

    // Reset during WAIT abandons the operation
    issue(INS_MUL, 8'h21, 8'h04);
    tick();
    tick();
    rdy_in  = 1'b1;
    reset_n = 1'b0;
    tick();
    check("t5_rst_strobes", {LDAcc, LDMQ, LDDR, STAcc, STMQ, STDR}, 0);
    check("t5_rst_ins", INS, 0);
    check("t5_rst_bus", inBUS, 0);
    check("t5_rst_valid", rsp_valid, 0);
    reset_n = 1'b1;
    tick();
    check("t5_rel_ready", cmd_ready, 1);
    st0 = st_count;
    repeat (4) tick();
    check("t5_no_st_after", st_count - st0, 0);
    check("t5_no_rsp_after", rsp_valid, 0);
    rdy_in = 1'b0;

    // Recovery with full-scale operands
    issue(INS_MUL, 8'hFF, 8'hFF);
    rdy_in = 1'b1;
    sb.push_back('{data: exp_of(8'hFF, 8'hFF), timeout: 1'b0});
    collect("t6", 0);

    check("sb_drained", sb.size(), 0);
    check("bus_invariants", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_bus_host.md
# alu_bus_host

Host-side sequencer for the 8-bit shift/add multiplier datapath's bus interface. It accepts one operation request (opcode plus two 8-bit operands), performs the register-load sequence on the datapath bus, and issues the instruction. It then waits for the datapath's RDY, reads Acc and MQ back over outBUS, and returns a 16-bit result through a valid/ready response channel. It sits between the system command fabric and the datapath; it is the only driver of the datapath's load/store strobes.

## Interface
Parameters:
- MIN_WAIT, 2: cycles after issue before RDY is sampled; range 1..15.
- TIMEOUT_CYCLES, 200: WAIT-state cycle budget, counted from the first RDY sample; range 1..255.

Ports:
- clock  in  1  rising-edge clock, shared with the datapath.
- reset_n  in  1  reset, synchronous and active-low.
- cmd_valid  in  1  request present.
- cmd_ready  out  1  host idle, accepts request.
- cmd_ins  in  3  datapath opcode.
- cmd_a  in  8  operand loaded into MQ.
- cmd_b  in  8  operand loaded into DR.
- rsp_valid  out  1  result held.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  16  {Acc, MQ} readback.
- rsp_timeout  out  1  RDY never seen; rsp_data is 0.
- INS  out  3  opcode to datapath.
- inBUS  out  8  write data to datapath.
- LDAcc, LDMQ, LDDR  out  1 each  load strobes.
- STAcc, STMQ, STDR  out  1 each  store (read-enable) strobes.
- TESTMODE  out  1  constant 0.
- outBUS  in  8  datapath read data, combinational from its registers.
- RDY  in  1  datapath ready.

## Operation
- States: IDLE, LD_DR, LD_MQ, LD_ACC, EXEC, WAIT, RD_ACC, RD_MQ, RESP.
- IDLE: cmd_ready=1. On cmd_valid, the host latches ins/a/b and moves to LD_DR.
- LD_DR: inBUS=b, LDDR=1. LD_MQ: inBUS=a, LDMQ=1. LD_ACC: inBUS=0, LDAcc=1.
- EXEC: INS=ins. wait_cnt is loaded with MIN_WAIT-1 and to_cnt with TIMEOUT_CYCLES. The FSM then moves to WAIT.
- WAIT: INS stays held. wait_cnt decrements to 0, and RDY is ignored until it reaches 0. After that, each cycle samples RDY:
  - RDY=1: go to RD_ACC.
  - RDY=0 with to_cnt=1: go to RESP with rsp_timeout=1 and rsp_data=0.
  - Otherwise to_cnt decrements.
- RD_ACC: STAcc=1, and outBUS is captured into rsp_data[15:8] at the clock edge. RD_MQ: STMQ=1, and outBUS is captured into rsp_data[7:0].
- RESP: rsp_valid=1. Transitions to IDLE on rsp_ready.
- At most one of the ST* strobes is high in any cycle. At most one of the LD* strobes is high. No LD* is ever high together with any ST*.
- inBUS is 0 in every state except LD_DR and LD_MQ. INS is 0 outside EXEC and WAIT.
- STDR is reserved and is always 0. It is driven only when DR_READBACK_EN is defined.
- cmd_* inputs are ignored outside IDLE.

## Timing
- All outputs are registered. Reset (reset_n=0 at an edge) forces state IDLE and every output to 0, except cmd_ready=1 from the first edge after reset release.
- Reset mid-operation abandons the operation immediately. No strobes are asserted afterward, and no response is produced.
- Latency from cmd accept to rsp_valid is 3 load cycles + EXEC + MIN_WAIT + k + 2 read cycles, where k is the number of RDY-sampling cycles (minimum 1, maximum TIMEOUT_CYCLES).
- A cmd_valid arriving in the same cycle that RESP completes is not accepted until the next cycle, because cmd_ready asserts only in IDLE.
- rsp_data and rsp_timeout stay stable while rsp_valid=1 and rsp_ready=0.

## Configuration
- DR_READBACK_EN defined:
  - RD_MQ is followed by a state RD_DR with STDR=1.
  - rsp_data widens to 24 bits as {Acc, MQ, DR}, and latency grows by one cycle.
  - On timeout, all 24 bits are 0.
- DR_READBACK_EN undefined: STDR is tied 0, rsp_data is 16 bits, and the RD_DR state does not exist.

## Structure
- Package alu_bus_pkg holds:
  - the state enum;
  - opcode constants (3-bit INS encodings);
  - localparam widths (DATA_W=8, INS_W=3);
  - the response width function selected by DR_READBACK_EN.
- Sub-module alu_bus_wait_timer holds wait_cnt and to_cnt. It has load and enable inputs and produces sample and expire outputs.
- The FSM and output registers stay in alu_bus_host.

## Test plan
- Request ins=3'b101, a=8'h0F, b=8'h03, with the model raising RDY 5 cycles after issue. The bus must show LDDR with inBUS=03, then LDMQ with 0F, then LDAcc with 00, then INS=101. After RDY, STAcc then STMQ must follow. With the model returning Acc=00 and MQ=2D, rsp_data must be 16'h002D.
- RDY already high at issue with MIN_WAIT=2: RDY must not be sampled until 2 cycles after EXEC, and RD_ACC must start on the third post-EXEC cycle.
- RDY stuck 0 with TIMEOUT_CYCLES=4: the host must reach RESP after exactly 4 sampling cycles with rsp_timeout=1 and rsp_data=0. No ST* strobe may assert.
- Backpressure: hold rsp_ready=0 for 10 cycles. rsp_valid and rsp_data must stay stable and cmd_ready must stay 0. On release, the host returns to IDLE in one cycle.
- Drive reset_n=0 during WAIT. On the next edge all strobes, INS and inBUS must be 0, and cmd_ready must be 1 after release.
- With DR_READBACK_EN defined and b=8'hA5: STDR must follow STMQ, and rsp_data[7:0] must equal A5.
